// File: rtl/rf_port_scheduler.sv
// Sequential register-file port scheduler: grants one masked batch of read/write
// slots onto free BRAM ports over several cycles. Optional macro RF_RR_PRIORITY_EN.

module rf_pick #(
   parameter int N   = 12,
   parameter int IDW = 4
) (
   input  logic           en,
   input  logic [N-1:0]   mask_i,
   input  logic [IDW-1:0] ptr,
   output logic           vld,
   output logic [IDW-1:0] id,
   output logic [N-1:0]   mask_o
);
   int idx;
   always_comb begin
      vld    = 1'b0;
      id     = '0;
      mask_o = mask_i;
      idx    = 0;
      // Search starts at ptr and wraps; claimed bit is removed for later ports.
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (en && !vld && mask_i[idx]) begin
            vld         = 1'b1;
            id          = IDW'(idx);
            mask_o[idx] = 1'b0;
         end
      end
   end
endmodule

module rf_port_scheduler #(
   parameter int NUM_RREQ   = 12,
   parameter int NUM_WREQ   = 6,
   parameter int NUM_RPORTS = 8,
   parameter int NUM_WPORTS = 2,
   parameter int RID_W      = $clog2(NUM_RREQ),
   parameter int WID_W      = $clog2(NUM_WREQ)
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [NUM_RREQ-1:0]                   r_read_mask,
   input  logic [NUM_RREQ-1:0]                   r_done_mask,
   input  logic [NUM_WREQ-1:0]                   w_read_mask,
   input  logic [NUM_WREQ-1:0]                   w_done_mask,
   input  logic [NUM_RPORTS-1:0]                 r_port_avail,
   input  logic [NUM_WPORTS-1:0]                 w_port_avail,
   output logic [NUM_RPORTS-1:0]                 r_grant_valid,
   output logic [NUM_RPORTS-1:0][RID_W-1:0]      r_grant_id,
   output logic [NUM_WPORTS-1:0]                 w_grant_valid,
   output logic [NUM_WPORTS-1:0][WID_W-1:0]      w_grant_id,
   input  logic                                  flush,
   output logic                                  batch_done,
   output logic [7:0]                            batch_cycles
);
   typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_e;

   state_e              state_q, state_d;
   logic [NUM_RREQ-1:0] r_pend_q, r_pend_d;
   logic [NUM_WREQ-1:0] w_pend_q, w_pend_d;
   logic [7:0]          cnt_q, cnt_d;
   logic [7:0]          batch_cycles_q, batch_cycles_d;
   logic [RID_W-1:0]    r_ptr;
   logic [WID_W-1:0]    w_ptr;
   logic                issue_go;

   logic [NUM_RPORTS:0][NUM_RREQ-1:0] r_chain;
   logic [NUM_WPORTS:0][NUM_WREQ-1:0] w_chain;

   assign issue_go   = (state_q == ISSUE) && !flush;
   assign r_chain[0] = r_pend_q;
   assign w_chain[0] = w_pend_q;

   // Ports form a claim chain: each picker sees only the slots left by lower ports.
   for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_rp
      rf_pick #(.N(NUM_RREQ), .IDW(RID_W)) u_pick (
         .en(issue_go && r_port_avail[p]), .mask_i(r_chain[p]), .ptr(r_ptr),
         .vld(r_grant_valid[p]), .id(r_grant_id[p]), .mask_o(r_chain[p+1]));
   end
   for (genvar p = 0; p < NUM_WPORTS; p++) begin : g_wp
      rf_pick #(.N(NUM_WREQ), .IDW(WID_W)) u_pick (
         .en(issue_go && w_port_avail[p]), .mask_i(w_chain[p]), .ptr(w_ptr),
         .vld(w_grant_valid[p]), .id(w_grant_id[p]), .mask_o(w_chain[p+1]));
   end

`ifdef RF_RR_PRIORITY_EN
   logic [RID_W-1:0]    r_ptr_q, r_ptr_d;
   logic [WID_W-1:0]    w_ptr_q, w_ptr_d;
   logic [NUM_RREQ-1:0] r_gnt;
   logic [NUM_WREQ-1:0] w_gnt;

   assign r_gnt = r_pend_q & ~r_chain[NUM_RPORTS];
   assign w_gnt = w_pend_q & ~w_chain[NUM_WPORTS];
   assign r_ptr = r_ptr_q;
   assign w_ptr = w_ptr_q;

   // Pointer lands one past the highest slot granted; ungranted cycles hold it.
   always_comb begin
      r_ptr_d = r_ptr_q;
      w_ptr_d = w_ptr_q;
      for (int i = 0; i < NUM_RREQ; i++)
         if (r_gnt[i]) r_ptr_d = (i == NUM_RREQ-1) ? '0 : RID_W'(i+1);
      for (int i = 0; i < NUM_WREQ; i++)
         if (w_gnt[i]) w_ptr_d = (i == NUM_WREQ-1) ? '0 : WID_W'(i+1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ptr_q <= '0;
         w_ptr_q <= '0;
      end else begin
         r_ptr_q <= r_ptr_d;
         w_ptr_q <= w_ptr_d;
      end
   end
`else
   assign r_ptr = '0;
   assign w_ptr = '0;
`endif

   always_comb begin
      state_d        = state_q;
      r_pend_d       = r_pend_q;
      w_pend_d       = w_pend_q;
      cnt_d          = cnt_q;
      batch_cycles_d = batch_cycles_q;
      req_ready      = 1'b0;
      batch_done     = 1'b0;
      batch_cycles   = batch_cycles_q;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid && !flush) begin
               r_pend_d = r_read_mask & ~r_done_mask;
               w_pend_d = w_read_mask & ~w_done_mask;
               cnt_d    = '0;
               state_d  = ((|r_pend_d) || (|w_pend_d)) ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if (flush) begin
               r_pend_d = '0;
               w_pend_d = '0;
               state_d  = IDLE;
            end else begin
               r_pend_d = r_chain[NUM_RPORTS];
               w_pend_d = w_chain[NUM_WPORTS];
               cnt_d    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
               if (!(|r_pend_d) && !(|w_pend_d)) state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (flush) begin
               r_pend_d = '0;
               w_pend_d = '0;
            end else begin
               batch_done     = 1'b1;
               batch_cycles   = cnt_q;
               batch_cycles_d = cnt_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         r_pend_q       <= '0;
         w_pend_q       <= '0;
         cnt_q          <= '0;
         batch_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         r_pend_q       <= r_pend_d;
         w_pend_q       <= w_pend_d;
         cnt_q          <= cnt_d;
         batch_cycles_q <= batch_cycles_d;
      end
   end
endmodule

// File: tb/tb_rf_port_scheduler.sv
// Bench for rf_port_scheduler (default fixed-priority build): table of batches
// checked against a queued per-cycle model, plus stall/flush/reset sequences.

module tb_rf_port_scheduler;
   logic                 clk = 1'b0;
   logic                 reset;
   logic                 req_valid, req_ready, flush, batch_done;
   logic [11:0]          r_read_mask, r_done_mask;
   logic [5:0]           w_read_mask, w_done_mask;
   logic [7:0]           r_port_avail, r_grant_valid, batch_cycles;
   logic [1:0]           w_port_avail, w_grant_valid;
   logic [7:0][3:0]      r_grant_id;
   logic [1:0][2:0]      w_grant_id;

   rf_port_scheduler dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .r_read_mask(r_read_mask), .r_done_mask(r_done_mask),
      .w_read_mask(w_read_mask), .w_done_mask(w_done_mask),
      .r_port_avail(r_port_avail), .w_port_avail(w_port_avail),
      .r_grant_valid(r_grant_valid), .r_grant_id(r_grant_id),
      .w_grant_valid(w_grant_valid), .w_grant_id(w_grant_id),
      .flush(flush), .batch_done(batch_done), .batch_cycles(batch_cycles));

   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] rr, rd;
      logic [5:0]  wr, wd;
      logic [7:0]  ra;
      logic [1:0]  wa;
      int          cyc;
   } vec_t;

   typedef struct packed {
      logic [7:0]      rv;
      logic [7:0][3:0] rid;
      logic [1:0]      wv;
      logic [1:0][2:0] wid;
      logic            done;
      logic [7:0]      bc;
   } exp_t;

   exp_t q[$];
   vec_t vecs[8];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected per-cycle grants for a batch whose avail inputs stay constant.
   task automatic push_batch(input vec_t v);
      logic [11:0] rp;
      logic [5:0]  wp;
      exp_t        e;
      int          cyc;
      rp  = v.rr & ~v.rd;
      wp  = v.wr & ~v.wd;
      cyc = 0;
      while ((rp != 0 || wp != 0) && cyc < 200) begin
         e = '0;
         for (int p = 0; p < 8; p++)
            if (v.ra[p])
               for (int s = 0; s < 12; s++)
                  if (rp[s]) begin
                     e.rv[p] = 1'b1; e.rid[p] = 4'(s); rp[s] = 1'b0; break;
                  end
         for (int p = 0; p < 2; p++)
            if (v.wa[p])
               for (int s = 0; s < 6; s++)
                  if (wp[s]) begin
                     e.wv[p] = 1'b1; e.wid[p] = 3'(s); wp[s] = 1'b0; break;
                  end
         cyc++;
         q.push_back(e);
      end
      e = '0; e.done = 1'b1; e.bc = 8'(cyc);
      q.push_back(e);
   endtask

   task automatic run_vec(input vec_t v, input int k);
      exp_t e;
      int   n;
      check($sformatf("v%0d ready_idle", k), 64'(req_ready), 64'd1);
      r_read_mask = v.rr; r_done_mask = v.rd; w_read_mask = v.wr; w_done_mask = v.wd;
      r_port_avail = v.ra; w_port_avail = v.wa; req_valid = 1'b1;
      push_batch(v);
      @(posedge clk); #1 req_valid = 1'b0;
      n = 0;
      while (q.size() > 0) begin
         @(negedge clk);
         e = q.pop_front();
         check($sformatf("v%0d c%0d rgrant", k, n), {r_grant_valid, r_grant_id}, {e.rv, e.rid});
         check($sformatf("v%0d c%0d wgrant", k, n), {w_grant_valid, w_grant_id}, {e.wv, e.wid});
         check($sformatf("v%0d c%0d done", k, n), 64'(batch_done), 64'(e.done));
         check($sformatf("v%0d c%0d ready", k, n), 64'(req_ready), 64'd0);
         if (e.done) check($sformatf("v%0d cycles", k), 64'(batch_cycles), 64'(v.cyc));
         n++;
      end
      @(negedge clk);
   endtask

   initial begin
      vecs[0] = '{12'hFFF, 12'h000, 6'h00, 6'h00, 8'hFF, 2'b11, 2};
      vecs[1] = '{12'h0F0, 12'h030, 6'h03, 6'h00, 8'hFF, 2'b11, 1};
      vecs[2] = '{12'h00F, 12'h000, 6'h00, 6'h00, 8'hAA, 2'b11, 1};
      vecs[3] = '{12'hFFF, 12'hFFF, 6'h3F, 6'h3F, 8'hFF, 2'b11, 0};
      vecs[4] = '{12'h000, 12'h000, 6'h3F, 6'h00, 8'hFF, 2'b11, 3};
      vecs[5] = '{12'hFFF, 12'h000, 6'h3F, 6'h00, 8'h0F, 2'b01, 6};
      vecs[6] = '{12'h000, 12'h000, 6'h00, 6'h00, 8'hFF, 2'b11, 0};
      vecs[7] = '{12'h800, 12'h000, 6'h20, 6'h00, 8'h80, 2'b10, 1};

      reset = 1'b0; req_valid = 1'b0; flush = 1'b0;
      r_read_mask = '0; r_done_mask = '0; w_read_mask = '0; w_done_mask = '0;
      r_port_avail = '0; w_port_avail = '0;
      #1;
      check("rst ready", 64'(req_ready), 64'd1);
      check("rst grants", {r_grant_valid, r_grant_id, w_grant_valid, w_grant_id}, 64'd0);
      check("rst done/cycles", {batch_done, batch_cycles}, 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Stall: all read ports busy for three ISSUE cycles.
      r_read_mask = 12'hFFF; r_done_mask = '0; w_read_mask = '0; w_done_mask = '0;
      r_port_avail = 8'h00; w_port_avail = 2'b00; req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check($sformatf("stall c%0d", c), {r_grant_valid, batch_done}, 64'd0);
      end
      @(posedge clk); #1 r_port_avail = 8'hFF;
      @(negedge clk);
      check("stall g1", {r_grant_valid, r_grant_id[0], r_grant_id[7]}, {8'hFF, 4'd0, 4'd7});
      @(negedge clk);
      check("stall g2", {r_grant_valid, r_grant_id[0], r_grant_id[3]}, {8'h0F, 4'd8, 4'd11});
      @(negedge clk);
      check("stall done", {batch_done, batch_cycles}, {1'b1, 8'd5});
      @(negedge clk);

      // Flush on the second ISSUE cycle.
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("flush g1", 64'(r_grant_valid), 64'hFF);
      @(posedge clk); #1 flush = 1'b1;
      #1 check("flush gv", 64'(r_grant_valid), 64'h0);
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush idle", {req_ready, batch_done, batch_cycles}, {1'b1, 1'b0, 8'd5});
      @(negedge clk);
      check("flush nodone", {req_ready, batch_done}, {1'b1, 1'b0});

      // Flush in IDLE blocks acceptance.
      flush = 1'b1; req_valid = 1'b1;
      @(posedge clk); #1 flush = 1'b0; req_valid = 1'b0;
      @(negedge clk);
      check("idle flush", {req_ready, r_grant_valid}, {1'b1, 8'h00});

      // Reset in the middle of ISSUE.
      req_valid = 1'b1;
      @(posedge clk); #1 req_valid = 1'b0;
      @(negedge clk);
      check("pre-rst grant", 64'(r_grant_valid), 64'hFF);
      reset = 1'b0;
      #1;
      check("mid rst grants", {r_grant_valid, r_grant_id, w_grant_valid}, 64'd0);
      check("mid rst state", {req_ready, batch_done, batch_cycles}, {1'b1, 1'b0, 8'd0});
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      run_vec(vecs[1], 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/rf_port_scheduler.md
Name: rf_port_scheduler

Overview:
- Sequential successor to the combinational register-file port selector.
- Accepts one batch of read and write register-file requests as masks, minus a pre-completed mask.
- Each cycle, grants up to NUM_RPORTS read and NUM_WPORTS write requests to the BRAM ports that are free. Retires granted bits, then signals batch completion.
- Sits between rename/issue and the BRAM register-file banks, which may stall individual ports.

Parameters:
- NUM_RREQ, 12, number of read request slots.
- NUM_WREQ, 6, number of write request slots.
- NUM_RPORTS, 8, read ports (NUM_BRAMS*2).
- NUM_WPORTS, 2, write ports.
- RID_W, $clog2(NUM_RREQ), read slot id width.
- WID_W, $clog2(NUM_WREQ), write slot id width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  batch offered.
- req_ready  out  1  scheduler can accept a batch.
- r_read_mask  in  NUM_RREQ  read slots requested.
- r_done_mask  in  NUM_RREQ  read slots already complete; sampled with the batch.
- w_read_mask  in  NUM_WREQ  write slots requested.
- w_done_mask  in  NUM_WREQ  write slots already complete; sampled with the batch.
- r_port_avail  in  NUM_RPORTS  read port may take a grant this cycle.
- w_port_avail  in  NUM_WPORTS  write port may take a grant this cycle.
- r_grant_valid  out  NUM_RPORTS  grant on read port p.
- r_grant_id  out  [NUM_RPORTS] x RID_W  slot granted on read port p.
- w_grant_valid  out  NUM_WPORTS  grant on write port p.
- w_grant_id  out  [NUM_WPORTS] x WID_W  slot granted on write port p.
- flush  in  1  synchronous abort of the current batch.
- batch_done  out  1  one-cycle pulse, batch fully granted.
- batch_cycles  out  8  ISSUE cycles used by the last batch, saturating at 255.

Behaviour:
- States: IDLE, ISSUE, DONE.
- Reset (reset=0, async):
  - state=IDLE; pending masks=0; batch_cycles=0; priority pointers=0.
  - req_ready=1; all grant_valid=0; all grant_id=0; batch_done=0.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge, load r_pend = r_read_mask & ~r_done_mask and w_pend = w_read_mask & ~w_done_mask, and clear the cycle counter.
  - Go to ISSUE if either pend is nonzero, otherwise go to DONE.
- ISSUE:
  - req_ready=0.
  - Grants are combinational from the registered pend masks and the avail inputs, and are valid in the same cycle.
  - Read grant order: available read ports are visited in increasing index. Each takes the lowest-index unclaimed set bit of r_pend. A port with avail=0 is skipped and does not consume a slot.
  - Write ports are granted from w_pend the same way.
  - No slot is granted twice in one cycle.
  - Unused ports have grant_valid=0 and grant_id=0.
  - At the edge, granted bits are cleared from pend and the counter is incremented, saturating at 255.
  - When both next-pend masks are 0, go to DONE.
- DONE:
  - batch_done=1 for exactly one cycle; batch_cycles is updated to the final count.
  - req_ready=0; go to IDLE.
- Latency:
  - Batch accepted at edge T; first grants appear in cycle T+1.
  - Minimum batch (all done) is accepted at T with batch_done in T+1.
- Stalls: if all ports are unavailable, no progress is made and the counter still increments.
- flush: in ISSUE or DONE, flush forces pend=0, grant_valid=0 that cycle, and a return to IDLE at the edge. No batch_done is produced and batch_cycles is not updated. flush in IDLE has no effect; it also blocks acceptance that cycle.
- Reset mid-batch: all state is cleared immediately and no done pulse is produced.

Optional Feature:
- RF_RR_PRIORITY_EN
- Defined:
  - Read and write slot search starts at a rotating pointer rather than at index 0, wrapping modulo NUM_RREQ or NUM_WREQ.
  - Each pointer advances at every ISSUE edge to one past the highest-index slot granted that cycle, wrapping.
  - A pointer does not advance if nothing was granted.
  - Pointers reset to 0 and persist across batches.
- Undefined: fixed lowest-index-first priority; no pointer registers exist.

Test Plan:
- Reset then r_read_mask=12'hFFF, r_done=0, w_read=0, all ports avail, req_valid pulse:
  - Cycle 1: read ports 0..7 get ids 0..7.
  - Cycle 2: ports 0..3 get ids 8..11.
  - Next cycle: batch_done=1 and batch_cycles=2.
- r_read_mask=12'h0F0, r_done_mask=12'h030, w_read=6'b000011, w_done=0: a single ISSUE cycle with read ids 6,7 on ports 0,1 and write ids 0,1 on w ports 0,1, then batch_done.
- r_read=12'h00F, r_port_avail=8'b1010_1010: ports 1,3,5,7 get ids 0,1,2,3; ports 0,2,4,6 invalid.
- Batch with all bits already done: req_ready=0 for one cycle, batch_done in the next cycle, batch_cycles=0, no grant_valid ever asserted.
- r_read=12'hFFF with r_port_avail=0 for 3 cycles then all 1:
  - No grants during the stall.
  - Completion after 2 more cycles with batch_cycles=5.
- Stress and optional feature:
  - Flush on the second ISSUE cycle: IDLE and req_ready=1 next cycle, no batch_done.
  - With RF_RR_PRIORITY_EN and NUM_RPORTS=1, r_read=12'h005 twice in back-to-back batches: first batch grants 0 then 2; second batch starts at 0 after wrap (pointer=3, search wraps, finds 0 then 2).
  - Reset asserted mid-ISSUE clears all outputs asynchronously.
